dtcu_scheduler: RTL

The display refresh scheduler sequences the Display Transmission Control Unit (DTCU) at the top of the GPU display path. After power-up it runs the panel init sequence, then issues periodic frame transfers at a fixed refresh rate. It swaps the front/back frame buffers on renderer request, but only at frame boundaries. It recovers from I2C NACKs and stalled transfers by resetting and re-initialising the DTCU.

---
 rtl/dtcu_scheduler.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/dtcu_scheduler.sv
// dtcu_scheduler: display refresh scheduler for the DTCU. Runs panel init after
// power-up, issues periodic frame transfers, swaps front/back buffers only at
// frame boundaries and recovers from NACKs or stalls by resetting the DTCU.
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   enable            permits frame transfers (init runs regardless)
//   dtcu_busy         DTCU busy indication
//   dtcu_nack         DTCU sticky NACK flag
//   swap_req          renderer has finished the back buffer (level)
//   init_display      one-cycle panel init request
//   send_frame        one-cycle frame transfer request
//   dtcu_reset        active-high reset for DTCU and I2C controller
//   swap_ack          one-cycle pulse when a buffer swap takes effect
//   front_buffer      buffer the DTCU reads; renderer draws into ~front_buffer
//   overrun           one-cycle pulse when a tick finds a frame still pending
//   error             sticky fault flag
//   frame_count       successful frame count, wraps
module dtcu_scheduler #(
    parameter int POWERUP_CYCLES = 100000,
    parameter int FRAME_PERIOD   = 833333,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int MAX_RETRIES    = 3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        dtcu_busy,
    input  logic        dtcu_nack,
    input  logic        swap_req,
    output logic        init_display,
    output logic        send_frame,
    output logic        dtcu_reset,
    output logic        swap_ack,
    output logic        front_buffer,
    output logic        overrun,
    output logic        error,
    output logic [15:0] frame_count
);
    localparam int CMAX = (POWERUP_CYCLES > TIMEOUT_CYCLES) ? POWERUP_CYCLES : TIMEOUT_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int FW   = $clog2(FRAME_PERIOD);
    localparam int RW   = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        POWERUP, INIT_REQ, INIT_WAIT, IDLE, FRAME_REQ, FRAME_WAIT, RECOVER, FAULT
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [FW-1:0] ftmr, ftmr_n;
    logic [RW-1:0] retry_cnt, retry_n;
    logic [15:0]   count_n;
    logic          run, run_n;
    logic          pending, pending_n;
    logic          busy_seen, busy_seen_n;
    logic          front_n, swap_n, overrun_n;
    logic          tick, done, timeout, consume;

    always_comb begin
        state_n     = state;
        cnt_n       = cnt + 1'b1;
        retry_n     = retry_cnt;
        count_n     = frame_count;
        run_n       = run;
        busy_seen_n = busy_seen;
        front_n     = front_buffer;
        swap_n      = 1'b0;
        consume     = 1'b0;
        tick        = run && (ftmr == FW'(FRAME_PERIOD - 1));
        ftmr_n      = run ? (tick ? '0 : ftmr + 1'b1) : '0;
        done        = busy_seen && !dtcu_busy;
        timeout     = (cnt == CW'(TIMEOUT_CYCLES));
        case (state)
            POWERUP: begin
                if (cnt == CW'(POWERUP_CYCLES)) begin
                    state_n = INIT_REQ;
                    cnt_n   = '0;
                end
            end
            // The watchdog counts from the request cycle (cnt is 0 there).
            INIT_REQ, FRAME_REQ: begin
                state_n     = (state == INIT_REQ) ? INIT_WAIT : FRAME_WAIT;
                busy_seen_n = 1'b0;
            end
            INIT_WAIT, FRAME_WAIT: begin
                busy_seen_n = busy_seen | dtcu_busy;
                if (done && !dtcu_nack) begin
                    state_n = IDLE;
                    retry_n = '0;
                    if (state == FRAME_WAIT) begin
                        count_n = frame_count + 1'b1;
                    end else begin
                        run_n  = 1'b1;
                        ftmr_n = '0;
                    end
                end else if (done || timeout) begin
                    state_n = RECOVER;
                    cnt_n   = '0;
                    retry_n = retry_cnt + 1'b1;
                    run_n   = 1'b0;
                end
            end
            IDLE: begin
                cnt_n = '0;
                if (pending && enable) begin
                    state_n = FRAME_REQ;
                    consume = 1'b1;
                    front_n = swap_req ? ~front_buffer : front_buffer;
                    swap_n  = swap_req;
                end
            end
            RECOVER: begin
                if (cnt == CW'(1)) begin
                    state_n = (retry_cnt >= RW'(MAX_RETRIES)) ? FAULT : INIT_REQ;
                    cnt_n   = '0;
                end
            end
            FAULT: cnt_n = cnt;
        endcase
        // A tick coinciding with IDLE exit still latches; recovery drops stale ticks.
        pending_n = (state_n == RECOVER) ? 1'b0 : (tick | (pending & ~consume));
        overrun_n = tick & pending & ~consume;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= POWERUP;
            cnt          <= '0;
            ftmr         <= '0;
            retry_cnt    <= '0;
            run          <= 1'b0;
            pending      <= 1'b0;
            busy_seen    <= 1'b0;
            init_display <= 1'b0;
            send_frame   <= 1'b0;
            dtcu_reset   <= 1'b1;
            swap_ack     <= 1'b0;
            front_buffer <= 1'b0;
            overrun      <= 1'b0;
            error        <= 1'b0;
            frame_count  <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            ftmr         <= ftmr_n;
            retry_cnt    <= retry_n;
            run          <= run_n;
            pending      <= pending_n;
            busy_seen    <= busy_seen_n;
            init_display <= (state_n == INIT_REQ);
            send_frame   <= (state_n == FRAME_REQ);
            dtcu_reset   <= (state_n inside {POWERUP, RECOVER, FAULT});
            swap_ack     <= swap_n;
            front_buffer <= front_n;
            overrun      <= overrun_n;
            error        <= (state_n == FAULT);
            frame_count  <= count_n;
        end
    end
endmodule
